// File: rtl/ble_pdu_deframer.sv
// ble_pdu_deframer
//   Takes the recovered symbol strobe and bit from the receiver and, after an
//   access-address match, dewhitens the PDU bits, assembles LSB-first bytes and
//   frames them as header / payload / CRC using the PDU length byte. Bytes leave
//   through a first-word-fall-through FIFO with a valid/ready handshake.
//
//   Build option: define BLE_DEWHITEN_EN to enable the x^7+x^4+1 dewhitening
//   LFSR seeded from channel. Without it, bits pass straight through and channel
//   is ignored.
//
//   Ports
//     clk, rst            clock, asynchronous active-high reset
//     update, value       symbol strobe (rising edge = one bit) and symbol bit
//     aa_match            access-address hit; the next update edge is PDU bit 0
//     channel             RF channel index, seeds the dewhitening LFSR
//     byte_data/last      FIFO head byte and end-of-frame flag
//     byte_valid/ready    FIFO handshake, pop on valid & ready
//     pkt_busy            framer active
//     pkt_done, len_err   1-cycle status pulses (registered)
//     abort               aa_match seen while busy (same cycle)
//     overflow            sticky byte-drop flag, cleared by aa_match
//     fifo_count          FIFO occupancy
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | waiting for aa_match, update edges ignored
//   HEADER  | bytes 0 and 1; byte 1 is the payload length L
//   PAYLOAD | L payload bytes
//   CRC     | 3 CRC bytes, the last one closes the frame
module ble_pdu_deframer #(
  parameter int FIFO_DEPTH  = 16,
  parameter int CNT_W       = 5,
  parameter int MAX_PDU_LEN = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             update,
  input  logic             value,
  input  logic             aa_match,
  input  logic [5:0]       channel,
  output logic [7:0]       byte_data,
  output logic             byte_last,
  output logic             byte_valid,
  input  logic             byte_ready,
  output logic             pkt_busy,
  output logic             pkt_done,
  output logic             len_err,
  output logic             abort,
  output logic             overflow,
  output logic [CNT_W-1:0] fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [7:0]       MAX_LEN_C = 8'(MAX_PDU_LEN);

  typedef enum logic [1:0] {S_IDLE, S_HEADER, S_PAYLOAD, S_CRC} state_t;

  state_t     state_q, state_d;
  logic       update_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] len_q, len_d;
  logic [7:0] sr_q, sr_d;
  logic       pkt_done_q, pkt_done_d;
  logic       len_err_q, len_err_d;
  logic       overflow_q, overflow_d;
  logic       edge_det, proc_bit, bit_val;
  logic [7:0] new_byte;
  logic       push, push_last, push_ok, pop;

  logic [8:0]       mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  assign edge_det = update & ~update_q;
  // aa_match wins over a coincident edge: that edge belongs to the old frame
  assign proc_bit = edge_det & (state_q != S_IDLE) & ~aa_match;
  assign new_byte = {bit_val, sr_q[7:1]};

`ifdef BLE_DEWHITEN_EN
  logic [6:0] lfsr_q, lfsr_d;
  logic       white;

  assign white   = lfsr_q[6];
  assign bit_val = value ^ white;

  always_comb begin
    lfsr_d = lfsr_q;
    if (aa_match)
      lfsr_d = {channel[0], channel[1], channel[2], channel[3], channel[4], channel[5], 1'b1};
    else if (proc_bit)
      lfsr_d = {lfsr_q[5], lfsr_q[4], lfsr_q[3] ^ white, lfsr_q[2], lfsr_q[1], lfsr_q[0], white};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= '0;
    else     lfsr_q <= lfsr_d;
  end
`else
  logic unused_channel;
  assign unused_channel = ^channel;
  assign bit_val        = value;
`endif

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    sr_d       = sr_q;
    pkt_done_d = 1'b0;
    len_err_d  = 1'b0;
    push       = 1'b0;
    push_last  = 1'b0;
    if (aa_match) begin
      state_d    = S_HEADER;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
      len_d      = '0;
      sr_d       = '0;
    end else if (proc_bit) begin
      sr_d      = new_byte;
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        push = 1'b1;
        case (state_q)
          S_HEADER: begin
            if (byte_cnt_q == 8'd0) begin
              byte_cnt_d = 8'd1;
            end else begin
              len_d      = new_byte;
              byte_cnt_d = '0;
              if (new_byte > MAX_LEN_C) begin
                push_last = 1'b1;
                len_err_d = 1'b1;
                state_d   = S_IDLE;
              end else if (new_byte == 8'd0) begin
                state_d = S_CRC;
              end else begin
                state_d = S_PAYLOAD;
              end
            end
          end
          S_PAYLOAD: begin
            if (byte_cnt_q == len_q - 8'd1) begin
              byte_cnt_d = '0;
              state_d    = S_CRC;
            end else begin
              byte_cnt_d = byte_cnt_q + 8'd1;
            end
          end
          S_CRC: begin
            if (byte_cnt_q == 8'd2) begin
              push_last  = 1'b1;
              pkt_done_d = 1'b1;
              byte_cnt_d = '0;
              state_d    = S_IDLE;
            end else begin
              byte_cnt_d = byte_cnt_q + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // A pop frees a slot in the same cycle, so a full FIFO can still take a push
  assign pop     = (count_q != '0) & byte_ready;
  assign push_ok = push & ((count_q < DEPTH_C) | pop);

  always_comb begin
    overflow_d = overflow_q;
    if (aa_match)               overflow_d = 1'b0;
    else if (push & ~push_ok)   overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      update_q   <= 1'b0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      len_q      <= '0;
      sr_q       <= '0;
      pkt_done_q <= 1'b0;
      len_err_q  <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      update_q   <= update;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      sr_q       <= sr_d;
      pkt_done_q <= pkt_done_d;
      len_err_q  <= len_err_d;
      overflow_q <= overflow_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(push_ok) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= {push_last, new_byte};
  end

  // Head is gated so stale storage never shows on the outputs after reset
  assign byte_valid = (count_q != '0);
  assign byte_data  = byte_valid ? mem_q[rd_ptr_q][7:0] : 8'h00;
  assign byte_last  = byte_valid & mem_q[rd_ptr_q][8];
  assign pkt_busy   = (state_q != S_IDLE);
  assign pkt_done   = pkt_done_q;
  assign len_err    = len_err_q;
  assign abort      = aa_match & (state_q != S_IDLE);
  assign overflow   = overflow_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_ble_pdu_deframer.sv
`timescale 1ns/1ps
module tb_ble_pdu_deframer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       update = 1'b0;
  logic       value = 1'b0;
  logic       aa_match = 1'b0;
  logic       byte_ready = 1'b0;
  logic [5:0] channel = 6'd37;
  logic [7:0] byte_data;
  logic       byte_last, byte_valid, pkt_busy, pkt_done, len_err, abort, overflow;
  logic [4:0] fifo_count;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int lerr_cnt = 0;
  int abort_cnt = 0;
  logic [8:0] cap_q[$];
  logic [6:0] tb_l = 7'h0;

  always #5 clk = ~clk;

  ble_pdu_deframer dut (
    .clk(clk), .rst(rst), .update(update), .value(value), .aa_match(aa_match),
    .channel(channel), .byte_data(byte_data), .byte_last(byte_last),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .pkt_busy(pkt_busy),
    .pkt_done(pkt_done), .len_err(len_err), .abort(abort), .overflow(overflow),
    .fifo_count(fifo_count)
  );

  // Inputs change 2ns after the rising edge; outputs are observed on the falling edge
  always @(negedge clk) begin
    if (byte_valid && byte_ready) cap_q.push_back({byte_last, byte_data});
    if (pkt_done) done_cnt++;
    if (len_err)  lerr_cnt++;
    if (abort)    abort_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Whitens the stimulus when the DUT dewhitens, so plain byte values decode unchanged
  task automatic send_bit(input logic b, input bit raw);
    logic v;
`ifdef BLE_DEWHITEN_EN
    logic w;
`endif
    v = b;
`ifdef BLE_DEWHITEN_EN
    w = tb_l[6];
    if (!raw) v = b ^ w;
    tb_l = {tb_l[5], tb_l[4], tb_l[3] ^ w, tb_l[2], tb_l[1], tb_l[0], w};
`else
    if (raw) v = b;
`endif
    update = 1'b1;
    value  = v;
    step();
    update = 1'b0;
    step();
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
  endtask

  task automatic pulse_aa();
    tb_l = {channel[0], channel[1], channel[2], channel[3], channel[4], channel[5], 1'b1};
    aa_match = 1'b1;
    step();
    aa_match = 1'b0;
  endtask

  task automatic test_reset();
    idle(3);
    n_checks++;
    if ({byte_data, byte_last, byte_valid, pkt_busy, pkt_done, len_err, abort, overflow, fifo_count} !== 20'h0)
      $display("FAIL reset_outputs: got %h want 0",
               {byte_data, byte_last, byte_valid, pkt_busy, pkt_done, len_err, abort, overflow, fifo_count});
    else n_pass++;
    rst = 1'b0;
    idle(2);
    send_byte(8'h5A);
    idle(2);
    n_checks++;
    if (fifo_count !== 5'd0) $display("FAIL idle_edges_count: got %0d want 0", fifo_count);
    else n_pass++;
    n_checks++;
    if (pkt_busy !== 1'b0) $display("FAIL idle_edges_busy: got %b want 0", pkt_busy);
    else n_pass++;
  endtask

  task automatic test_basic_frame();
    logic [8:0] exp [5];
    int d0;
    exp = '{9'h002, 9'h000, 9'h0AA, 9'h0BB, 9'h1CC};
    byte_ready = 1'b1;
    cap_q.delete();
    d0 = done_cnt;
    pulse_aa();
    n_checks++;
    if (pkt_busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", pkt_busy);
    else n_pass++;
    send_byte(8'h02); send_byte(8'h00); send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    idle(4);
    n_checks++;
    if (cap_q.size() != 5) $display("FAIL basic_nbytes: got %0d want 5", cap_q.size());
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      if (i < cap_q.size()) begin
        n_checks++;
        if (cap_q[i] !== exp[i]) $display("FAIL basic_byte%0d: got %h want %h", i, cap_q[i], exp[i]);
        else n_pass++;
      end
    end
    n_checks++;
    if (done_cnt - d0 != 1) $display("FAIL basic_done: got %0d pulses want 1", done_cnt - d0);
    else n_pass++;
    n_checks++;
    if (pkt_busy !== 1'b0) $display("FAIL basic_idle: got %b want 0", pkt_busy);
    else n_pass++;
  endtask

  task automatic test_len_err();
    int l0, d0;
    byte_ready = 1'b1;
    cap_q.delete();
    l0 = lerr_cnt;
    d0 = done_cnt;
    pulse_aa();
    send_byte(8'h02); send_byte(8'h40);
    idle(3);
    n_checks++;
    if (cap_q.size() != 2) $display("FAIL lenerr_nbytes: got %0d want 2", cap_q.size());
    else n_pass++;
    if (cap_q.size() == 2) begin
      n_checks++;
      if (cap_q[0] !== 9'h002) $display("FAIL lenerr_byte0: got %h want 002", cap_q[0]);
      else n_pass++;
      n_checks++;
      if (cap_q[1] !== 9'h140) $display("FAIL lenerr_byte1: got %h want 140", cap_q[1]);
      else n_pass++;
    end
    n_checks++;
    if (lerr_cnt - l0 != 1 || done_cnt != d0)
      $display("FAIL lenerr_pulses: got len_err %0d done %0d want 1 0", lerr_cnt - l0, done_cnt - d0);
    else n_pass++;
    n_checks++;
    if (pkt_busy !== 1'b0) $display("FAIL lenerr_idle: got %b want 0", pkt_busy);
    else n_pass++;
    send_byte(8'h55);
    idle(3);
    n_checks++;
    if (cap_q.size() != 2 || fifo_count !== 5'd0)
      $display("FAIL lenerr_ignored: got %0d bytes count %0d want 2 0", cap_q.size(), fifo_count);
    else n_pass++;
  endtask

  task automatic test_overflow();
    int d0, a0, nlast;
    byte_ready = 1'b0;
    cap_q.delete();
    d0 = done_cnt;
    pulse_aa();
    send_byte(8'h02); send_byte(8'h14);
    for (int i = 0; i < 20; i++) send_byte(8'(i));
    send_byte(8'hC0); send_byte(8'hC1); send_byte(8'hC2);
    idle(3);
    n_checks++;
    if (fifo_count !== 5'd16) $display("FAIL ovf_count: got %0d want 16", fifo_count);
    else n_pass++;
    n_checks++;
    if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow);
    else n_pass++;
    n_checks++;
    if (done_cnt - d0 != 1) $display("FAIL ovf_done: got %0d pulses want 1", done_cnt - d0);
    else n_pass++;
    a0 = abort_cnt;
    pulse_aa();
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow);
    else n_pass++;
    n_checks++;
    if (abort_cnt != a0) $display("FAIL ovf_noabort: got %0d pulses want 0", abort_cnt - a0);
    else n_pass++;
    byte_ready = 1'b1;
    idle(20);
    n_checks++;
    if (cap_q.size() != 16) $display("FAIL ovf_drain: got %0d bytes want 16", cap_q.size());
    else n_pass++;
    if (cap_q.size() == 16) begin
      n_checks++;
      if (cap_q[1] !== 9'h014 || cap_q[15] !== 9'h00D)
        $display("FAIL ovf_content: got %h %h want 014 00d", cap_q[1], cap_q[15]);
      else n_pass++;
      nlast = 0;
      foreach (cap_q[i]) if (cap_q[i][8]) nlast++;
      n_checks++;
      if (nlast != 0) $display("FAIL ovf_nolast: got %0d last flags want 0", nlast);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    logic [8:0] exp [5];
    int a0, d0;
    exp = '{9'h00E, 9'h000, 9'h012, 9'h034, 9'h156};
    byte_ready = 1'b1;
    pulse_aa();
    cap_q.delete();
    send_byte(8'h02); send_byte(8'h05); send_byte(8'h11);
    idle(2);
    n_checks++;
    if (pkt_busy !== 1'b1) $display("FAIL abort_busy: got %b want 1", pkt_busy);
    else n_pass++;
    a0 = abort_cnt;
    pulse_aa();
    idle(1);
    n_checks++;
    if (abort_cnt - a0 != 1) $display("FAIL abort_pulse: got %0d pulses want 1", abort_cnt - a0);
    else n_pass++;
    n_checks++;
    if (cap_q.size() != 3 || (cap_q.size() == 3 && (cap_q[0] !== 9'h002 || cap_q[1] !== 9'h005 || cap_q[2] !== 9'h011)))
      $display("FAIL abort_kept: got %0d bytes want 002 005 011 without last", cap_q.size());
    else n_pass++;
    cap_q.delete();
    d0 = done_cnt;
    send_byte(8'h0E); send_byte(8'h00); send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    idle(3);
    n_checks++;
    if (cap_q.size() != 5) $display("FAIL abort_reframe_n: got %0d want 5", cap_q.size());
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      if (i < cap_q.size()) begin
        n_checks++;
        if (cap_q[i] !== exp[i]) $display("FAIL abort_reframe%0d: got %h want %h", i, cap_q[i], exp[i]);
        else n_pass++;
      end
    end
    n_checks++;
    if (done_cnt - d0 != 1) $display("FAIL abort_done: got %0d pulses want 1", done_cnt - d0);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int d0;
    byte_ready = 1'b0;
    pulse_aa();
    send_byte(8'h02); send_byte(8'h03); send_byte(8'hA1);
    idle(1);
    n_checks++;
    if (fifo_count !== 5'd3) $display("FAIL rstmid_pre: got %0d want 3", fifo_count);
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({byte_data, byte_last, byte_valid, pkt_busy, pkt_done, len_err, abort, overflow, fifo_count} !== 20'h0)
      $display("FAIL rstmid_outputs: got %h want 0",
               {byte_data, byte_last, byte_valid, pkt_busy, pkt_done, len_err, abort, overflow, fifo_count});
    else n_pass++;
    step(); step();
    rst = 1'b0;
    send_byte(8'hFF);
    idle(2);
    n_checks++;
    if (fifo_count !== 5'd0 || pkt_busy !== 1'b0)
      $display("FAIL rstmid_ignored: got count %0d busy %b want 0 0", fifo_count, pkt_busy);
    else n_pass++;
    byte_ready = 1'b1;
    cap_q.delete();
    d0 = done_cnt;
    pulse_aa();
    send_byte(8'h00); send_byte(8'h00); send_byte(8'hC1); send_byte(8'hC2); send_byte(8'hC3);
    idle(3);
    n_checks++;
    if (cap_q.size() != 5 || (cap_q.size() == 5 && (cap_q[4] !== 9'h1C3 || cap_q[3] !== 9'h0C2)))
      $display("FAIL rstmid_frame: got %0d bytes want 5 ending c2,last c3", cap_q.size());
    else n_pass++;
    n_checks++;
    if (done_cnt - d0 != 1) $display("FAIL rstmid_done: got %0d pulses want 1", done_cnt - d0);
    else n_pass++;
  endtask

`ifdef BLE_DEWHITEN_EN
  task automatic test_dewhiten();
    byte_ready = 1'b1;
    channel = 6'd37;
    cap_q.delete();
    pulse_aa();
    for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b1);
    idle(2);
    n_checks++;
    if (cap_q.size() < 1 || cap_q[0] !== 9'h08D)
      $display("FAIL dewhiten_byte: got %0d bytes first %h want 08d", cap_q.size(), cap_q.size() > 0 ? cap_q[0] : 9'h0);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_frame();
    test_len_err();
    test_overflow();
    test_abort();
    test_reset_mid();
`ifdef BLE_DEWHITEN_EN
    test_dewhiten();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
